// File: rtl/usb_buff_pkt_fifo.sv
// Store-and-forward packet FIFO: holds each packet until its last word lands,
// presents only complete packets, and drops packets that cannot fit.
module usb_buff_pkt_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     ext_clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_last,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_oversize
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {ST_ACCEPT, ST_DROP} state_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pkt_start_q, pkt_start_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  state_t        state_q, state_d;
  logic          err_q, err_d;
  logic          full, store, pkt_in, pkt_out, rd_hs;
  entry_t        head;

  // Show-ahead read port; data is forced to zero while nothing is presented
  assign level        = wr_ptr_q - rd_ptr_q;
  assign full         = (level == PW'(DEPTH));
  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_valid     = (pkt_count_q != '0);
  assign rd_data      = rd_valid ? head.data : '0;
  assign rd_last      = rd_valid & head.last;
  assign rd_hs        = rd_valid & rd_ready;
  assign pkt_out      = rd_hs & head.last;
  assign pkt_count    = pkt_count_q;
  assign err_oversize = err_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_start_d = pkt_start_q;
    pkt_count_d = pkt_count_q;
    err_d       = 1'b0;
    wr_ready    = 1'b1;
    store       = 1'b0;
    pkt_in      = 1'b0;

    if (rd_hs) rd_ptr_d = rd_ptr_q + PW'(1);

    case (state_q)
      ST_ACCEPT: begin
        wr_ready = !full;
        if (wr_valid && !full) begin
          store    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (wr_last) begin
            pkt_start_d = wr_ptr_q + PW'(1);
            pkt_in      = 1'b1;
          end
        end else if (wr_valid && full && (pkt_count_q == '0)) begin
          // Packet can never fit: rewind over its stored words and discard the rest
          err_d    = 1'b1;
          wr_ptr_d = pkt_start_q;
          state_d  = ST_DROP;
        end
      end
      ST_DROP: begin
        if (wr_valid && wr_last) state_d = ST_ACCEPT;
      end
      default: state_d = ST_ACCEPT;
    endcase

    case ({pkt_in, pkt_out})
      2'b10:   pkt_count_d = pkt_count_q + PW'(1);
      2'b01:   pkt_count_d = pkt_count_q - PW'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ACCEPT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_start_q <= '0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_start_q <= pkt_start_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset; pointers define what is valid
  always_ff @(posedge ext_clk) begin
    if (store) mem_q[wr_ptr_q[AW-1:0]] <= entry_t'{last: wr_last, data: wr_data};
  end

endmodule

// File: tb/tb_usb_buff_pkt_fifo.sv
// Bench for usb_buff_pkt_fifo: directed scenarios plus random traffic against a
// packet-queue reference model.
module tb_usb_buff_pkt_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = 5;
  localparam int unsigned VW    = 4 + 2 * PW + DW;

  logic          ext_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          wr_valid = 1'b0, wr_last = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_valid, rd_last, err_oversize;
  logic [DW-1:0] rd_data;
  logic [PW-1:0] pkt_count, level;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: complete words as {last,data}, plus the packet being written
  logic [DW:0]   m_q[$];
  logic [DW-1:0] m_part[$];
  int            m_npkt = 0;
  bit            m_drop = 0;
  bit            m_err  = 0;

  logic          e_wr_ready, e_rd_valid, e_rd_last, e_err;
  logic [DW-1:0] e_rd_data;
  int            e_level, e_cnt;

  usb_buff_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .ext_clk(ext_clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .pkt_count(pkt_count), .level(level), .err_oversize(err_oversize)
  );

  always #5 ext_clk = ~ext_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic logic [VW-1:0] obs();
    return {wr_ready, rd_valid, rd_last, err_oversize, pkt_count, level, rd_data};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_wr_ready, e_rd_valid, e_rd_last, e_err, PW'(e_cnt), PW'(e_level), e_rd_data};
  endfunction

  task automatic model_clear();
    m_q.delete(); m_part.delete();
    m_npkt = 0; m_drop = 0; m_err = 0;
  endtask

  // Drive one cycle, snapshot model expectations for it, then advance the model
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic wl, input logic rr);
    int words;
    logic [DW:0] w;
    @(negedge ext_clk);
    wr_valid = wv; wr_data = wd; wr_last = wl; rd_ready = rr;
    #1;
    words      = m_q.size() + m_part.size();
    e_wr_ready = m_drop || (words != DEPTH);
    e_rd_valid = (m_npkt != 0);
    e_rd_data  = e_rd_valid ? m_q[0][DW-1:0] : '0;
    e_rd_last  = e_rd_valid ? m_q[0][DW] : 1'b0;
    e_level    = words;
    e_cnt      = m_npkt;
    e_err      = m_err;
    m_err      = 0;
    if (e_rd_valid && rr) begin
      w = m_q.pop_front();
      if (w[DW]) m_npkt--;
    end
    if (m_drop) begin
      if (wv && wl) m_drop = 0;
    end else if (wv && e_wr_ready) begin
      m_part.push_back(wd);
      if (wl) begin
        foreach (m_part[i]) m_q.push_back({1'(i == m_part.size() - 1), m_part[i]});
        m_npkt++;
        m_part.delete();
      end
    end else if (wv && e_cnt == 0) begin
      m_drop = 1; m_err = 1;
      m_part.delete();
    end
  endtask

  task automatic apply_reset();
    @(negedge ext_clk);
    #2;
    reset = 1'b1;
    wr_valid = 0; wr_last = 0; wr_data = '0; rd_ready = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge ext_clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    logic [VW-1:0] want;
    apply_reset();
    want = {1'b1, 1'b0, 1'b0, 1'b0, PW'(0), PW'(0), DW'(0)};
    n_cmp++;
    if (obs() !== want) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs(), want);
    end
    release_reset();
  endtask

  task automatic test_cut_through();
    step(1, 32'hA1, 0, 1);
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL ct_early_valid: got %b want 0", rd_valid); end
    step(1, 32'hA2, 0, 1);
    step(1, 32'hA3, 1, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if ({rd_valid, rd_data, rd_last, pkt_count} !== {1'b1, 32'hA1, 1'b0, PW'(1)}) begin
      n_bad++; $display("FAIL ct_word1: got v=%b d=%h l=%b c=%0d want v=1 d=a1 l=0 c=1", rd_valid, rd_data, rd_last, pkt_count);
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if ({rd_valid, rd_data, rd_last} !== {1'b1, 32'hA2, 1'b0}) begin
      n_bad++; $display("FAIL ct_word2: got v=%b d=%h l=%b want v=1 d=a2 l=0", rd_valid, rd_data, rd_last);
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if ({rd_valid, rd_data, rd_last} !== {1'b1, 32'hA3, 1'b1}) begin
      n_bad++; $display("FAIL ct_word3: got v=%b d=%h l=%b want v=1 d=a3 l=1", rd_valid, rd_data, rd_last);
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if ({rd_valid, rd_data, rd_last, pkt_count, level} !== {1'b0, 32'h0, 1'b0, PW'(0), PW'(0)}) begin
      n_bad++; $display("FAIL ct_empty: got v=%b d=%h l=%b c=%0d lv=%0d want all 0", rd_valid, rd_data, rd_last, pkt_count, level);
    end
  endtask

  task automatic test_full_backpressure();
    for (int p = 0; p < 4; p++)
      for (int w = 0; w < 4; w++) step(1, DW'(32'hB00 + p * 4 + w), w == 3, 0);
    step(1, 32'hB17, 1, 0);
    n_cmp++;
    if ({wr_ready, level, pkt_count} !== {1'b0, PW'(16), PW'(4)}) begin
      n_bad++; $display("FAIL full_hold: got rdy=%b lv=%0d c=%0d want rdy=0 lv=16 c=4", wr_ready, level, pkt_count);
    end
    step(1, 32'hB17, 1, 1);
    n_cmp++;
    if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_read_cycle: got rdy=%b want 0", wr_ready); end
    step(1, 32'hB17, 1, 0);
    n_cmp++;
    if ({wr_ready, level} !== {1'b1, PW'(15)}) begin
      n_bad++; $display("FAIL full_release: got rdy=%b lv=%0d want rdy=1 lv=15", wr_ready, level);
    end
    repeat (20) begin
      step(0, 0, 0, 1);
      n_cmp++;
      if (obs() !== exp_vec()) begin n_bad++; $display("FAIL full_drain: got %h want %h", obs(), exp_vec()); end
    end
    n_cmp++;
    if ({rd_valid, level} !== {1'b0, PW'(0)}) begin
      n_bad++; $display("FAIL full_drained: got v=%b lv=%0d want v=0 lv=0", rd_valid, level);
    end
  endtask

  task automatic test_oversize();
    int errs = 0;
    int rv = 0;
    int tries;
    for (int i = 1; i <= 20; i++) begin
      tries = 0;
      do begin
        step(1, DW'(32'hC000_0000 + i), i == 20, 0);
        tries++;
        if (err_oversize === 1'b1) errs++;
        if (rd_valid !== 1'b0) rv++;
        n_cmp++;
        if (obs() !== exp_vec()) begin n_bad++; $display("FAIL ovs_word%0d: got %h want %h", i, obs(), exp_vec()); end
        if (i == 17 && tries == 1) begin
          n_cmp++;
          if ({wr_ready, level, err_oversize} !== {1'b0, PW'(16), 1'b0}) begin
            n_bad++; $display("FAIL ovs_full: got rdy=%b lv=%0d err=%b want rdy=0 lv=16 err=0", wr_ready, level, err_oversize);
          end
        end
        if (i == 17 && tries == 2) begin
          n_cmp++;
          if ({wr_ready, level, err_oversize} !== {1'b1, PW'(0), 1'b1}) begin
            n_bad++; $display("FAIL ovs_drop: got rdy=%b lv=%0d err=%b want rdy=1 lv=0 err=1", wr_ready, level, err_oversize);
          end
        end
      end while (!e_wr_ready && tries < 4);
    end
    step(0, 0, 0, 0);
    if (err_oversize === 1'b1) errs++;
    if (rd_valid !== 1'b0) rv++;
    n_cmp++;
    if (errs !== 1) begin n_bad++; $display("FAIL ovs_err_pulses: got %0d want 1", errs); end
    n_cmp++;
    if (rv !== 0) begin n_bad++; $display("FAIL ovs_rd_valid_cycles: got %0d want 0", rv); end
    step(1, 32'hD1, 0, 0);
    step(1, 32'hD2, 1, 0);
    step(0, 0, 0, 1);
    n_cmp++;
    if ({rd_valid, rd_data, rd_last} !== {1'b1, 32'hD1, 1'b0}) begin
      n_bad++; $display("FAIL ovs_next1: got v=%b d=%h l=%b want v=1 d=d1 l=0", rd_valid, rd_data, rd_last);
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if ({rd_valid, rd_data, rd_last} !== {1'b1, 32'hD2, 1'b1}) begin
      n_bad++; $display("FAIL ovs_next2: got v=%b d=%h l=%b want v=1 d=d2 l=1", rd_valid, rd_data, rd_last);
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if ({rd_valid, level} !== {1'b0, PW'(0)}) begin
      n_bad++; $display("FAIL ovs_empty: got v=%b lv=%0d want v=0 lv=0", rd_valid, level);
    end
  endtask

  task automatic test_simultaneous();
    step(1, 32'hE1, 1, 0);
    step(0, 0, 0, 0);
    n_cmp++;
    if ({pkt_count, level, rd_data, rd_last} !== {PW'(1), PW'(1), 32'hE1, 1'b1}) begin
      n_bad++; $display("FAIL sim_held: got c=%0d lv=%0d d=%h l=%b want c=1 lv=1 d=e1 l=1", pkt_count, level, rd_data, rd_last);
    end
    step(1, 32'hE2, 1, 1);
    step(0, 0, 0, 0);
    n_cmp++;
    if ({pkt_count, level, rd_data, rd_last} !== {PW'(1), PW'(1), 32'hE2, 1'b1}) begin
      n_bad++; $display("FAIL sim_after: got c=%0d lv=%0d d=%h l=%b want c=1 lv=1 d=e2 l=1", pkt_count, level, rd_data, rd_last);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    n_cmp++;
    if ({rd_valid, level, pkt_count} !== {1'b0, PW'(0), PW'(0)}) begin
      n_bad++; $display("FAIL sim_empty: got v=%b lv=%0d c=%0d want 0 0 0", rd_valid, level, pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] want;
    for (int p = 0; p < 2; p++) begin
      step(1, DW'(32'hF00 + 2 * p), 0, 0);
      step(1, DW'(32'hF01 + 2 * p), 1, 0);
    end
    for (int w = 0; w < 5; w++) step(1, DW'(32'hF10 + w), 0, 0);
    step(0, 0, 0, 0);
    n_cmp++;
    if ({level, pkt_count} !== {PW'(9), PW'(2)}) begin
      n_bad++; $display("FAIL rmid_before: got lv=%0d c=%0d want lv=9 c=2", level, pkt_count);
    end
    apply_reset();
    want = {1'b1, 1'b0, 1'b0, 1'b0, PW'(0), PW'(0), DW'(0)};
    n_cmp++;
    if (obs() !== want) begin n_bad++; $display("FAIL rmid_async: got %h want %h", obs(), want); end
    release_reset();
    step(1, 32'hF51, 0, 0);
    step(1, 32'hF52, 1, 0);
    step(0, 0, 0, 1);
    n_cmp++;
    if ({rd_valid, rd_data, rd_last, pkt_count} !== {1'b1, 32'hF51, 1'b0, PW'(1)}) begin
      n_bad++; $display("FAIL rmid_first: got v=%b d=%h l=%b c=%0d want v=1 d=f51 l=0 c=1", rd_valid, rd_data, rd_last, pkt_count);
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if ({rd_valid, rd_data, rd_last} !== {1'b1, 32'hF52, 1'b1}) begin
      n_bad++; $display("FAIL rmid_second: got v=%b d=%h l=%b want v=1 d=f52 l=1", rd_valid, rd_data, rd_last);
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if ({rd_valid, level} !== {1'b0, PW'(0)}) begin
      n_bad++; $display("FAIL rmid_empty: got v=%b lv=%0d want 0 0", rd_valid, level);
    end
  endtask

  // Random valid/ready with lengths 1-12 and occasional packets too long to fit
  task automatic test_random();
    int words = 0;
    int cycles = 0;
    int left;
    logic [DW-1:0] cur;
    logic wv, rr;
    left = $urandom_range(1, 12);
    cur  = $urandom;
    while (words < 10000 && cycles < 60000) begin
      wv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 6);
      step(wv, cur, left == 1, rr);
      cycles++;
      n_cmp++;
      if (obs() !== exp_vec()) begin
        n_bad++; $display("FAIL rand_cycle%0d: got %h want %h", cycles, obs(), exp_vec());
      end
      if (wv && e_wr_ready) begin
        words++;
        left--;
        cur = $urandom;
        if (left == 0) left = ($urandom_range(0, 19) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 12);
      end
    end
    n_cmp++;
    if (words < 10000) begin n_bad++; $display("FAIL rand_budget: got %0d words want 10000", words); end
    repeat (40) begin
      step(0, cur, 1'b0, 1);
      n_cmp++;
      if (obs() !== exp_vec()) begin n_bad++; $display("FAIL rand_drain: got %h want %h", obs(), exp_vec()); end
    end
    n_cmp++;
    if (pkt_count !== PW'(0)) begin n_bad++; $display("FAIL rand_pkts_left: got %0d want 0", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_cut_through();
    test_full_backpressure();
    test_oversize();
    test_simultaneous();
    test_reset_mid();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
